// File: rtl/wavegen_dds.sv
// wavegen_dds: multi-channel DDS waveform generator.
// Each channel runs a phase accumulator and produces sine (external LUT),
// triangle, square, PWM or sawtooth samples. Settings are double-buffered
// (pending -> active) and commit on accumulator wrap, while disabled, or on
// sync, so that a retune never glitches mid-period. The output pipeline is
// acc -> stage 1 (LUT address, mode, phase bits) -> stage 2 (sample).
module wavegen_dds #(
   parameter int NCH    = 2,
   parameter int ACC_W  = 32,
   parameter int LUT_AW = 8,
   parameter int DATA_W = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cfg_we,
   input  logic [2:0]              cfg_ch,
   input  logic [2:0]              cfg_addr,
   input  logic [31:0]             cfg_wdata,
   output logic                    cfg_err,
   input  logic                    sync,
   output logic [NCH*LUT_AW-1:0]   lut_addr,
   input  logic [NCH*DATA_W-1:0]   lut_data,
   output logic [NCH*DATA_W-1:0]   wave_out,
   output logic [NCH-1:0]          wave_valid
);

   // Top accumulator bits carried into stage 1: enough for the triangle
   // (sign bit plus DATA_W bits) and for the 8-bit PWM compare.
   localparam int TOP_W = (DATA_W + 1 > 8) ? DATA_W + 1 : 8;
   localparam logic [DATA_W-1:0] FULL = '1;
   localparam logic [3:0] NCH_L = 4'(NCH);

   // Per-channel state: accumulator, pending and active settings, enable.
   logic [ACC_W-1:0]  acc     [NCH];
   logic [ACC_W-1:0]  acc_sum [NCH];
   logic [ACC_W-1:0]  fword_p [NCH];
   logic [ACC_W-1:0]  fword_a [NCH];
   logic [ACC_W-1:0]  phase_p [NCH];
   logic [ACC_W-1:0]  phase_a [NCH];
   logic [7:0]        duty_p  [NCH];
   logic [7:0]        duty_a  [NCH];
   logic [2:0]        mode_p  [NCH];
   logic [2:0]        mode_a  [NCH];
   logic [NCH-1:0]    en;
   logic [NCH-1:0]    en_nxt;
   logic [NCH-1:0]    wrap;
   logic [NCH-1:0]    wr_sel;
   logic              illegal;

   // Stage 1 and stage 2 pipeline registers.
   logic [LUT_AW-1:0] lut_addr_p1 [NCH];
   logic [TOP_W-1:0]  top_p1      [NCH];
   logic [2:0]        mode_p1     [NCH];
   logic [7:0]        duty_p1     [NCH];
   logic [NCH-1:0]    vld_p1;
   logic [DATA_W-1:0] wave_p2     [NCH];
   logic [NCH-1:0]    vld_p2;

   // Waveform function applied to the stage-1 phase bits.
   function automatic logic [DATA_W-1:0] shape(input logic [2:0]        mode,
                                               input logic [TOP_W-1:0]  top,
                                               input logic [7:0]        duty,
                                               input logic [DATA_W-1:0] lut);
      logic [DATA_W-1:0] tri_v;
      logic [DATA_W-1:0] saw_v;
      logic [7:0]        ph8;
      tri_v = top[TOP_W-2 -: DATA_W];
      saw_v = top[TOP_W-1 -: DATA_W];
      ph8   = top[TOP_W-1 -: 8];
      case (mode)
         3'd0:    shape = lut;
         3'd1:    shape = top[TOP_W-1] ? ~tri_v : tri_v;
         3'd2:    shape = top[TOP_W-1] ? '0 : FULL;
         3'd3:    shape = (ph8 < duty) ? FULL : '0;
         3'd4:    shape = saw_v;
         default: shape = '0;
      endcase
   endfunction

   // Decode the config write: legality, channel select, next enable state,
   // and the accumulator add with its carry (wrap).
   always_comb begin
      illegal = ({1'b0, cfg_ch} >= NCH_L) || (cfg_addr > 3'd4) ||
                ((cfg_addr == 3'd2) && (cfg_wdata > 32'd4));
      wr_sel = '0;
      en_nxt = en;
      wrap   = '0;
      for (int c = 0; c < NCH; c++) begin
         wr_sel[c] = cfg_we && !illegal && (cfg_ch == 3'(c));
         if (wr_sel[c] && (cfg_addr == 3'd4))
            en_nxt[c] = cfg_wdata[0];
         {wrap[c], acc_sum[c]} = {1'b0, acc[c]} + {1'b0, fword_a[c]};
      end
   end

   // Config registers, commit of pending to active, and accumulator update.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cfg_err <= 1'b0;
         en      <= '0;
         for (int c = 0; c < NCH; c++) begin
            acc[c]     <= '0;
            fword_p[c] <= '0;
            fword_a[c] <= '0;
            phase_p[c] <= '0;
            phase_a[c] <= '0;
            duty_p[c]  <= 8'd128;
            duty_a[c]  <= 8'd128;
            mode_p[c]  <= 3'd0;
            mode_a[c]  <= 3'd0;
         end
      end else begin
         cfg_err <= cfg_we && illegal;
         en      <= en_nxt;
         for (int c = 0; c < NCH; c++) begin
            // Commit uses the pending values from before this cycle's write.
            if (!en[c] || wrap[c] || sync) begin
               fword_a[c] <= fword_p[c];
               phase_a[c] <= phase_p[c];
               duty_a[c]  <= duty_p[c];
               mode_a[c]  <= mode_p[c];
            end
            // Disabled channels track the pending phase, so the first enabled
            // cycle starts from the freshly committed phase.
            if (!en[c] || sync)
               acc[c] <= phase_p[c];
            else
               acc[c] <= acc_sum[c];
            if (wr_sel[c]) begin
               case (cfg_addr)
                  3'd0:    fword_p[c] <= ACC_W'(cfg_wdata);
                  3'd1:    duty_p[c]  <= cfg_wdata[7:0];
                  3'd2:    mode_p[c]  <= cfg_wdata[2:0];
                  3'd3:    phase_p[c] <= ACC_W'(cfg_wdata);
                  default: ;
               endcase
            end
         end
      end
   end

   // ---- stage 1: LUT address and valid ----
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_p1 <= '0;
         for (int c = 0; c < NCH; c++)
            lut_addr_p1[c] <= '0;
      end else begin
         vld_p1 <= en & en_nxt;
         for (int c = 0; c < NCH; c++)
            lut_addr_p1[c] <= acc[c][ACC_W-1 -: LUT_AW];
      end
   end

   // Stage 1 data carried alongside the LUT address.
   always_ff @(posedge clk) begin
      for (int c = 0; c < NCH; c++) begin
         top_p1[c]  <= acc[c][ACC_W-1 -: TOP_W];
         mode_p1[c] <= mode_a[c];
         duty_p1[c] <= duty_a[c];
      end
   end

   // ---- stage 2: output sample, forced to zero when not valid ----
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_p2 <= '0;
         for (int c = 0; c < NCH; c++)
            wave_p2[c] <= '0;
      end else begin
         vld_p2 <= vld_p1 & en_nxt;
         for (int c = 0; c < NCH; c++)
            wave_p2[c] <= (vld_p1[c] && en_nxt[c]) ?
                          shape(mode_p1[c], top_p1[c], duty_p1[c],
                                lut_data[c*DATA_W +: DATA_W]) : '0;
      end
   end

   for (genvar g = 0; g < NCH; g++) begin : g_pack
      assign lut_addr[g*LUT_AW +: LUT_AW] = lut_addr_p1[g];
      assign wave_out[g*DATA_W +: DATA_W] = wave_p2[g];
   end
   assign wave_valid = vld_p2;

endmodule

// File: tb/tb_wavegen_dds.sv
// Directed testbench for wavegen_dds (NCH=2, ACC_W=32, 8-bit LUT and data).
// The sine LUT is modelled combinationally as data = addr + 1.
module tb_wavegen_dds;

   localparam int NCH    = 2;
   localparam int ACC_W  = 32;
   localparam int LUT_AW = 8;
   localparam int DATA_W = 8;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  cfg_we;
   logic [2:0]            cfg_ch;
   logic [2:0]            cfg_addr;
   logic [31:0]           cfg_wdata;
   logic                  cfg_err;
   logic                  sync;
   logic [NCH*LUT_AW-1:0] lut_addr;
   logic [NCH*DATA_W-1:0] lut_data;
   logic [NCH*DATA_W-1:0] wave_out;
   logic [NCH-1:0]        wave_valid;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int e;
   int step;
   int s0;

   wavegen_dds #(.NCH(NCH), .ACC_W(ACC_W), .LUT_AW(LUT_AW), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
      .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_err(cfg_err),
      .sync(sync), .lut_addr(lut_addr), .lut_data(lut_data),
      .wave_out(wave_out), .wave_valid(wave_valid)
   );

   always #5 clk = ~clk;

   // Sine LUT model: data = addr + 1.
   always_comb begin
      lut_data = '0;
      for (int c = 0; c < NCH; c++)
         lut_data[c*DATA_W +: DATA_W] = lut_addr[c*LUT_AW +: LUT_AW] + 8'd1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] w(input int c);
      return 32'(wave_out[c*DATA_W +: DATA_W]);
   endfunction

   function automatic logic [31:0] la(input int c);
      return 32'(lut_addr[c*LUT_AW +: LUT_AW]);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic wr(input logic [2:0] ch, input logic [2:0] a, input logic [31:0] d);
      cfg_we    = 1'b1;
      cfg_ch    = ch;
      cfg_addr  = a;
      cfg_wdata = d;
      tick();
      cfg_we    = 1'b0;
   endtask

   task automatic run_pwm(input int duty);
      wr(3'd0, 3'd0, 32'h0100_0000);
      wr(3'd0, 3'd2, 32'd3);
      wr(3'd0, 3'd1, 32'(duty));
      wr(3'd0, 3'd4, 32'd1);
      tick();
      tick();
      for (int k = 0; k < 256; k++) begin
         check($sformatf("pwm%0d", duty), w(0), (k < duty) ? 32'd255 : 32'd0);
         tick();
      end
      wr(3'd0, 3'd4, 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_addr = '0; cfg_wdata = '0; sync = 1'b0;
      tick();
      tick();
      check("rst_wave", 32'(wave_out), 32'd0);
      check("rst_valid", 32'(wave_valid), 32'd0);
      check("rst_lut", 32'(lut_addr), 32'd0);
      check("rst_err", 32'(cfg_err), 32'd0);
      rst_n = 1'b1;

      // Sawtooth on ch0, ch1 idle.
      wr(3'd0, 3'd0, 32'h0100_0000);
      wr(3'd0, 3'd2, 32'd4);
      wr(3'd0, 3'd4, 32'd1);
      check("en_vld_1", 32'(wave_valid), 32'd0);
      tick();
      check("en_vld_2", 32'(wave_valid), 32'd0);
      tick();
      for (int k = 0; k < 260; k++) begin
         check("saw0", w(0), k % 256);
         check("saw_vld", 32'(wave_valid), 32'd1);
         check("saw1", w(1), 32'd0);
         tick();
      end

      // Retune when acc is at 100 (output lags by 2, so output shows 98).
      e = 4;
      while (e != 98) begin
         tick();
         e++;
      end
      check("retune_pre", w(0), 32'd98);
      wr(3'd0, 3'd0, 32'h0200_0000);
      check("retune_err", 32'(cfg_err), 32'd0);
      e = 99;
      step = 1;
      for (int k = 0; k < 200; k++) begin
         check("retune", w(0), e);
         if (e == 255) begin
            e = 0;
            step = 2;
         end else begin
            e = (e + step) % 256;
         end
         tick();
      end

      wr(3'd0, 3'd4, 32'd0);
      check("dis_vld", 32'(wave_valid), 32'd0);
      check("dis_wave", w(0), 32'd0);

      // PWM duty 64, 0, 255.
      run_pwm(64);
      run_pwm(0);
      run_pwm(255);

      // Sine via LUT: lut_addr follows acc top byte, output = addr + 1.
      wr(3'd0, 3'd2, 32'd0);
      wr(3'd0, 3'd4, 32'd1);
      tick();
      check("sine_addr0", la(0), 32'd0);
      tick();
      for (int k = 0; k < 300; k++) begin
         check("sine", w(0), (k + 1) % 256);
         check("sine_addr", la(0), (k + 1) % 256);
         tick();
      end
      wr(3'd0, 3'd4, 32'd0);

      // Triangle at FWORD 2^23: 0..255 then 255..0.
      wr(3'd0, 3'd0, 32'h0080_0000);
      wr(3'd0, 3'd2, 32'd1);
      wr(3'd0, 3'd4, 32'd1);
      tick();
      tick();
      for (int k = 0; k < 512; k++) begin
         check("tri", w(0), (k < 256) ? k : 511 - k);
         tick();
      end
      wr(3'd0, 3'd4, 32'd0);

      // Square at FWORD 2^24: high for the first half period.
      wr(3'd0, 3'd0, 32'h0100_0000);
      wr(3'd0, 3'd2, 32'd2);
      wr(3'd0, 3'd4, 32'd1);
      tick();
      tick();
      for (int k = 0; k < 256; k++) begin
         check("square", w(0), (k < 128) ? 32'd255 : 32'd0);
         tick();
      end
      wr(3'd0, 3'd4, 32'd0);

      // Sync: ch0 phase 0, ch1 phase 2^31, both saw.
      wr(3'd0, 3'd2, 32'd4);
      wr(3'd0, 3'd3, 32'd0);
      wr(3'd1, 3'd0, 32'h0100_0000);
      wr(3'd1, 3'd2, 32'd4);
      wr(3'd1, 3'd3, 32'h8000_0000);
      wr(3'd0, 3'd4, 32'd1);
      tick();
      tick();
      tick();
      wr(3'd1, 3'd4, 32'd1);
      for (int k = 0; k < 5; k++) tick();
      sync = 1'b1;
      tick();
      sync = 1'b0;
      tick();
      tick();
      s0 = cyc;
      for (int k = 0; k < 300; k++) begin
         check("sync0", w(0), (cyc - s0) % 256);
         check("sync1", w(1), (cyc - s0 + 128) % 256);
         check("sync_vld", 32'(wave_valid), 32'd3);
         tick();
      end

      // Illegal writes: bad channel, bad address, bad mode value.
      wr(3'd3, 3'd0, 32'd5);
      check("err_ch", 32'(cfg_err), 32'd1);
      tick();
      check("err_ch_clr", 32'(cfg_err), 32'd0);
      wr(3'd0, 3'd6, 32'd0);
      check("err_addr", 32'(cfg_err), 32'd1);
      tick();
      check("err_addr_clr", 32'(cfg_err), 32'd0);
      wr(3'd0, 3'd2, 32'd7);
      check("err_mode", 32'(cfg_err), 32'd1);
      tick();
      check("err_mode_clr", 32'(cfg_err), 32'd0);
      for (int k = 0; k < 300; k++) begin
         check("post_err0", w(0), (cyc - s0) % 256);
         check("post_err1", w(1), (cyc - s0 + 128) % 256);
         tick();
      end

      // Mid-run reset drops pending writes and restores defaults.
      wr(3'd0, 3'd2, 32'd2);
      rst_n = 1'b0;
      tick();
      check("mrst_wave", 32'(wave_out), 32'd0);
      check("mrst_valid", 32'(wave_valid), 32'd0);
      check("mrst_lut", 32'(lut_addr), 32'd0);
      check("mrst_err", 32'(cfg_err), 32'd0);
      rst_n = 1'b1;
      wr(3'd0, 3'd0, 32'h0100_0000);
      wr(3'd0, 3'd4, 32'd1);
      tick();
      tick();
      for (int k = 0; k < 20; k++) begin
         check("mrst_sine", w(0), (k + 1) % 256);
         check("mrst_vld", 32'(wave_valid), 32'd1);
         check("mrst_ch1", w(1), 32'd0);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/wavegen_dds.md
# wavegen_dds

Multi-channel, parametrised direct-digital-synthesis waveform generator and the successor to the single-channel counter-stepped generator. Each channel has a phase accumulator, a frequency tuning word, a duty setting and a mode: sine (from an external LUT), triangle, square, PWM or sawtooth. New settings are double-buffered and take effect only at a period boundary, so output is glitch-free. A synchronous phase-align pulse restarts all channels. The block sits between the AXI-lite register front end and the DAC/PWM output stage.

## Interface
- NCH, 2, number of channels (1..8)
- ACC_W, 32, phase accumulator width (≥ LUT_AW+1, ≥ DATA_W+1)
- LUT_AW, 8, sine LUT address width
- DATA_W, 8, sample width
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- cfg_we  in  1  config write strobe, one cycle per write
- cfg_ch  in  3  target channel
- cfg_addr  in  3  register: 0 FWORD, 1 DUTY, 2 MODE, 3 PHASE, 4 CTRL
- cfg_wdata  in  32  write data, LSB-aligned
- cfg_err  out  1  one-cycle pulse, the cycle after an illegal write
- sync  in  1  phase-align pulse for all channels
- lut_addr  out  NCH*LUT_AW  per-channel sine LUT address (channel c at [c*LUT_AW +: LUT_AW])
- lut_data  in  NCH*DATA_W  LUT data, valid exactly one cycle after lut_addr
- wave_out  out  NCH*DATA_W  per-channel sample
- wave_valid  out  NCH  channel enabled and pipeline primed

## Operation
- Each channel holds pending registers (fword[ACC_W], duty[8], mode[3], phase[ACC_W]) and active copies. The datapath uses only the active copies.
- CTRL bit0 is enable. It is not shadowed and applies on the next cycle.
- Illegal writes are dropped and pulse cfg_err: cfg_ch ≥ NCH, cfg_addr 5–7, or MODE value > 4.
- While enabled, each cycle: acc ← acc + fword_active (mod 2^ACC_W). A carry out of that add is a wrap.
- Commit (pending → active, all four fields) happens on:
  - a wrap;
  - any cycle while the channel is disabled;
  - sync.
- A cfg write in the same cycle as a commit is not included in that commit. It commits at the next boundary.
- fword_active = 0 never wraps. Changes then need a disable or sync.
- Enable rising edge (0→1 transition) loads acc ← phase_active. While disabled, acc holds phase_pending.
- sync (any cycle) loads acc ← phase_pending and commits on every enabled channel simultaneously. Disabled channels ignore sync except for the commit.
- Mode encoding and output function (A = acc, M = 2^DATA_W − 1):
  - 0 SINE: lut_addr = A[ACC_W-1 -: LUT_AW]; output = lut_data.
  - 1 TRIANGLE: t = A[ACC_W-2 -: DATA_W]; output = A[ACC_W-1] ? ~t : t.
  - 2 SQUARE: output = A[ACC_W-1] ? 0 : M.
  - 3 PWM: output = (A[ACC_W-1 -: 8] < duty) ? M : 0. duty 0 gives constant 0; duty 255 gives high for 255 of 256 phase steps.
  - 4 SAW: output = A[ACC_W-1 -: DATA_W].
- DUTY is used only in PWM. PHASE is only used at load points.
- Disabled channel: wave_out = 0, wave_valid = 0.

## Timing
- Pipeline is 3 stages and identical for all modes:
  - cycle n: acc value;
  - cycle n+1: lut_addr registered, plus mode and phase bits registered;
  - cycle n+2: wave_out registered from lut_data or the computed function.
- Latency from acc to wave_out is 2 cycles for every mode. A mode change therefore never misaligns samples.
- wave_valid rises 2 cycles after the enable-load cycle and falls on the cycle after enable is cleared. wave_out is 0 in that same cycle.
- cfg_err is asserted in cycle n+1 for an illegal write in cycle n.
- Reset values:
  - acc 0;
  - pending and active: fword 0, duty 128, mode 0, phase 0;
  - enable 0;
  - lut_addr 0, wave_out 0, wave_valid 0, cfg_err 0.
- Reset mid-operation clears everything within one cycle, including pending writes.

## Test plan
- Saw: NCH=2, ch0 FWORD = 2^24, MODE 4, enable → wave_out ch0 steps 0,1,2…255,0 one per cycle, first valid 2 cycles after enable. Ch1 stays 0 with wave_valid 0.
- Glitch-free retune: ch0 saw at FWORD 2^24; write FWORD 2^25 at acc phase 100 → steps stay 1/cycle through 255, then 0,2,4…; one cycle of cfg_err? No, cfg_err stays 0.
- PWM: MODE 3, FWORD 2^24 → duty 64 gives 64 cycles at 255 and 192 at 0 per period. Duty 0 gives constant 0. Duty 255 gives a single 0 cycle per period.
- Sine and triangle: LUT model returning addr+1; MODE 0 → wave_out = lut_addr+1, 2 cycles after the acc value. Triangle at FWORD 2^23 ramps 0→255→0 over 512 cycles.
- Sync: ch0 PHASE 0, ch1 PHASE 2^31, both saw, pulse sync → in the same cycle ch0 outputs 0 and ch1 outputs 128, and they stay 128 apart.
- Errors and reset: write cfg_ch=3 (NCH=2), cfg_addr=6, and MODE=7 → cfg_err pulses once per write with no state change. Assert rst_n=0 mid-run for 1 cycle → all outputs 0 next cycle, and mode reads back as SINE behaviour after re-enable.
